rmii_mac_tx: RTL and testbench

//  Ethernet 100BASE-TX transmit MAC for the RMII PHY PMOD, clocked at 50 MHz by the RMII reference clock.

---
 rtl/rmii_mac_tx_pkg.sv | 21 ++
 rtl/rmii_mac_tx_if.sv | 24 ++
 rtl/rmii_mac_tx_crc.sv | 22 ++
 rtl/rmii_mac_tx.sv | 206 ++++++++++++++++++++
 tb/tb_rmii_mac_tx.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rmii_mac_tx_pkg.sv
// Shared types and constants for the RMII transmit MAC.
// The CRC constants are also used by the receive-side checker.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY_R  = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;

endpackage

// File: rtl/rmii_mac_tx_if.sv
// Byte-stream handshake between the fabric and the transmit MAC.
// The fabric is the master; the MAC is the slave.
interface rmii_mac_tx_if;

  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tready;

  modport master (
    output s_tdata,
    output s_tvalid,
    output s_tlast,
    input  s_tready
  );

  modport slave (
    input  s_tdata,
    input  s_tvalid,
    input  s_tlast,
    output s_tready
  );

endinterface

// File: rtl/rmii_mac_tx_crc.sv
// One-byte step of the reflected CRC-32 used by Ethernet.
// Purely combinational so tx and rx paths can share it.
module eth_crc32_byte
  import eth_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ CRC32_POLY_R;
      else      c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/rmii_mac_tx.sv
// 100BASE-TX RMII transmit MAC: preamble/SFD, padding, FCS, IFG.
// All ports are flops loaded from the next-state decode.
module rmii_mac_tx
  import eth_tx_pkg::*;
#(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_FRAME      = 60,
  parameter int MAX_FRAME      = 1514,
  parameter int IFG_BYTES      = 12
) (
  input  logic         clk,
  input  logic         rst,
  rmii_mac_tx_if.slave s,
  output logic [1:0]   rmii_txd,
  output logic         rmii_tx_en,
  output logic         busy,
  output logic         frame_done,
  output logic         underrun,
  output logic         oversize
);

  tx_state_t   state_q, state_d;
  logic [1:0]  di_q, di_d;
  logic [5:0]  slot_q, slot_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] txsh_q, txsh_d;
  logic [31:0] crc_q, crc_d, crc_nx;
  logic        last_q, last_d;
  logic        drain_q, drain_d;
  logic        un_ev, ov_ev;
  logic [7:0]  crc_data;

  logic        tready_q, tready_d;
  logic [1:0]  txd_d;
  logic        tx_en_d, busy_d, done_d;

  // PAD bytes and the post-tlast slot feed zeros into the CRC
  assign crc_data =
    (state_q == SFD || (state_q == DATA && !last_q)) ? s.s_tdata : 8'h00;

  eth_crc32_byte u_crc (
    .crc_in  (crc_q),
    .data    (crc_data),
    .crc_out (crc_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      di_q       <= 2'd0;
      slot_q     <= 6'd0;
      byte_cnt_q <= 11'd0;
      txsh_q     <= 32'h0;
      crc_q      <= CRC32_INIT;
      last_q     <= 1'b0;
      drain_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      di_q       <= di_d;
      slot_q     <= slot_d;
      byte_cnt_q <= byte_cnt_d;
      txsh_q     <= txsh_d;
      crc_q      <= crc_d;
      last_q     <= last_d;
      drain_q    <= drain_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    di_d       = di_q + 2'd1;
    slot_d     = slot_q;
    byte_cnt_d = byte_cnt_q;
    txsh_d     = txsh_q;
    crc_d      = crc_q;
    last_d     = last_q;
    drain_d    = drain_q;
    un_ev      = 1'b0;
    ov_ev      = 1'b0;
    if (drain_q && s.s_tvalid && s.s_tlast) drain_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        di_d   = 2'd0;
        slot_d = 6'd0;
        if (s.s_tvalid) begin
          state_d    = PRE;
          txsh_d     = {24'h0, ETH_PREAMBLE};
          crc_d      = CRC32_INIT;
          byte_cnt_d = 11'd0;
          last_d     = 1'b0;
        end
      end
      PRE: begin
        if (di_q == 2'd3) begin
          if (slot_q == 6'(PREAMBLE_BYTES - 1)) begin
            state_d = SFD;
            slot_d  = 6'd0;
            txsh_d  = {24'h0, ETH_SFD};
          end else begin
            slot_d = slot_q + 6'd1;
          end
        end
      end
      SFD, DATA: begin
        if (di_q == 2'd3) begin
          if (last_q) begin
            if (byte_cnt_q < 11'(MIN_FRAME)) begin
              state_d    = PAD;
              txsh_d     = 32'h0;
              crc_d      = crc_nx;
              byte_cnt_d = byte_cnt_q + 11'd1;
            end else begin
              state_d = FCS;
              slot_d  = 6'd0;
              txsh_d  = ~crc_q;
            end
          end else if (!s.s_tvalid) begin
            // uncomplemented CRC makes the receiver drop the frame
            un_ev   = 1'b1;
            state_d = FCS;
            slot_d  = 6'd0;
            txsh_d  = crc_q;
          end else if (byte_cnt_q == 11'(MAX_FRAME)) begin
            ov_ev   = 1'b1;
            drain_d = !s.s_tlast;
            state_d = FCS;
            slot_d  = 6'd0;
            txsh_d  = crc_q;
          end else begin
            state_d    = DATA;
            txsh_d     = {24'h0, s.s_tdata};
            crc_d      = crc_nx;
            byte_cnt_d = byte_cnt_q + 11'd1;
            last_d     = s.s_tlast;
          end
        end
      end
      PAD: begin
        if (di_q == 2'd3) begin
          if (byte_cnt_q < 11'(MIN_FRAME)) begin
            txsh_d     = 32'h0;
            crc_d      = crc_nx;
            byte_cnt_d = byte_cnt_q + 11'd1;
          end else begin
            state_d = FCS;
            slot_d  = 6'd0;
            txsh_d  = ~crc_q;
          end
        end
      end
      FCS: begin
        if (di_q == 2'd3) begin
          txsh_d = txsh_q >> 8;
          if (slot_q == 6'd3) begin
            state_d = IFG;
            slot_d  = 6'd0;
          end else begin
            slot_d = slot_q + 6'd1;
          end
        end
      end
      IFG: begin
        // the IDLE cycle is the last idle dibit on the wire
        if (slot_q == 6'(IFG_BYTES - 1) && di_q == 2'd2) begin
          di_d = di_q;
          if (!drain_d) state_d = IDLE;
        end else if (di_q == 2'd3) begin
          slot_d = slot_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_en_d  = state_d inside {PRE, SFD, DATA, PAD, FCS};
    txd_d    = tx_en_d ? txsh_d[{di_d, 1'b0} +: 2] : 2'b00;
    busy_d   = state_d != IDLE;
    done_d   = state_d == FCS && slot_d == 6'd3 && di_d == 2'd3;
    tready_d = drain_d ||
      ((state_d == SFD || state_d == DATA) && di_d == 2'd3 && !last_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rmii_txd   <= 2'b00;
      rmii_tx_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      oversize   <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      rmii_txd   <= txd_d;
      rmii_tx_en <= tx_en_d;
      busy       <= busy_d;
      frame_done <= done_d;
      underrun   <= un_ev;
      oversize   <= ov_ev;
      tready_q   <= tready_d;
    end
  end

  assign s.s_tready = tready_q;

endmodule

// File: tb/tb_rmii_mac_tx.sv
// Directed bench for rmii_mac_tx: frame table plus corner sequences.
// A wire monitor rebuilds each frame and checks it against a model.
module tb_rmii_mac_tx;
  import eth_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] rmii_txd;
  logic       rmii_tx_en, busy, frame_done, underrun, oversize;

  rmii_mac_tx_if bus ();

  rmii_mac_tx dut (
    .clk        (clk),
    .rst        (rst),
    .s          (bus),
    .rmii_txd   (rmii_txd),
    .rmii_tx_en (rmii_tx_en),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun),
    .oversize   (oversize)
  );

  always #10 clk = ~clk;

  typedef struct {
    int    len;
    int    stop;
    int    nd;
    int    exp_en;
    bit    good;
    int    un;
    int    ov;
    string name;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int seed, input int i);
    int v;
    v = i * 13 + seed * 29 + 1;
    return v[7:0];
  endfunction

  function automatic logic [31:0] crc_step(input logic [31:0] c,
                                           input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // wire monitor
  int         cyc = 0;
  logic [7:0] cur_q[$];
  logic [7:0] last_q[$];
  logic [7:0] acc_b = 8'h0;
  int         mdi = 0;
  int         en_cnt = 0, fd_pos = -1, low_cnt = 0;
  int         cur_gap = 0, rise_cyc = 0, cur_rdy = -1;
  int         last_en = 0, last_fd = 0, last_gap = 0, last_rdy = 0;
  int         frames = 0, un_cnt = 0, ov_cnt = 0, idle_bad = 0;
  logic       prev_en = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    un_cnt += int'(underrun);
    ov_cnt += int'(oversize);
    if (!rmii_tx_en && rmii_txd != 2'b00) idle_bad++;
    if (rmii_tx_en) begin
      if (!prev_en) begin
        cur_gap  = low_cnt;
        rise_cyc = cyc;
        cur_rdy  = -1;
        en_cnt   = 0;
        mdi      = 0;
        fd_pos   = -1;
        cur_q.delete();
      end
      en_cnt++;
      acc_b[2*mdi +: 2] = rmii_txd;
      if (mdi == 3) begin
        cur_q.push_back(acc_b);
        mdi = 0;
      end else begin
        mdi++;
      end
      if (frame_done) fd_pos = en_cnt;
      if (bus.s_tready && cur_rdy < 0) cur_rdy = cyc - rise_cyc;
    end else begin
      if (prev_en) begin
        frames++;
        last_q   = cur_q;
        last_en  = en_cnt;
        last_fd  = fd_pos;
        last_gap = cur_gap;
        last_rdy = cur_rdy;
        low_cnt  = 0;
      end
      low_cnt++;
    end
    prev_en = rmii_tx_en;
  end

  task automatic drive_frame(input int len, input int stop,
                             input int seed, output bit ok);
    bit acc;
    int g;
    ok = 1'b1;
    for (int i = 0; i < len && i < stop && ok; i++) begin
      bus.s_tdata  = pat(seed, i);
      bus.s_tvalid = 1'b1;
      bus.s_tlast  = (i == len - 1);
      g   = 0;
      acc = 1'b0;
      while (!acc && ok) begin
        @(negedge clk);
        acc = bus.s_tready;
        @(posedge clk);
        #1;
        g++;
        if (g > 500) ok = 1'b0;
      end
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.s_tdata  = 8'h00;
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while (g < 20000) begin
      @(negedge clk);
      if (!busy) break;
      g++;
    end
    if (g >= 20000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_idle: busy still %0d want 0", name, busy);
    end
  endtask

  task automatic run_vec(input vec_t v, input int seed);
    int          f0, u0, o0, n, nb, bad;
    bit          ok;
    logic [31:0] c, fcs;
    logic [7:0]  e;
    f0 = frames;
    u0 = un_cnt;
    o0 = ov_cnt;
    drive_frame(v.len, v.stop, seed, ok);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_drive: tready 0 want 1 within 500 cycles", v.name);
    end
    wait_idle(v.name);
    check({v.name, "_frames"}, frames - f0, 1);
    check({v.name, "_en"}, last_en, v.exp_en);
    check({v.name, "_done"}, last_fd, v.exp_en);
    check({v.name, "_gap"}, int'(last_gap >= 48), 1);
    check({v.name, "_rdy"}, last_rdy, 31);
    check({v.name, "_un"}, un_cnt - u0, v.un);
    check({v.name, "_ov"}, ov_cnt - o0, v.ov);
    n = last_q.size();
    check({v.name, "_size"}, n, v.exp_en / 4);
    if (n == v.exp_en / 4) begin
      bad = 0;
      for (int i = 0; i < 7; i++) if (last_q[i] != ETH_PREAMBLE) bad++;
      if (last_q[7] != ETH_SFD) bad++;
      check({v.name, "_pre"}, bad, 0);
      bad = 0;
      c   = CRC32_INIT;
      nb  = (v.good && v.nd < 60) ? 60 : v.nd;
      for (int i = 0; i < nb; i++) begin
        e = (i < v.nd) ? pat(seed, i) : 8'h00;
        if (last_q[8+i] !== e) bad++;
        c = crc_step(c, e);
      end
      check({v.name, "_data"}, bad, 0);
      fcs = {last_q[n-1], last_q[n-2], last_q[n-3], last_q[n-4]};
      check({v.name, "_fcs"}, int'(fcs), int'(v.good ? ~c : c));
      if (v.good) begin
        c = CRC32_INIT;
        for (int i = 8; i < n; i++) c = crc_step(c, last_q[i]);
        check({v.name, "_residue"}, int'(c), int'(CRC32_RESIDUE));
      end
    end
  endtask

  vec_t vecs[7];

  initial begin
    int f0, u0;
    bit ok;
    bus.s_tdata  = 8'h00;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;

    vecs[0] = '{60,   9999, 60,   288,  1'b1, 0, 0, "f60"};
    vecs[1] = '{14,   9999, 14,   288,  1'b1, 0, 0, "f14pad"};
    vecs[2] = '{100,  20,   20,   128,  1'b0, 1, 0, "under"};
    vecs[3] = '{61,   9999, 61,   292,  1'b1, 0, 0, "f61"};
    vecs[4] = '{1514, 9999, 1514, 6104, 1'b1, 0, 0, "max"};
    vecs[5] = '{1600, 9999, 1514, 6104, 1'b0, 0, 1, "over"};
    vecs[6] = '{64,   9999, 64,   304,  1'b1, 0, 0, "postover"};

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_outs", int'({rmii_tx_en, rmii_txd, busy, frame_done,
                             underrun, oversize, bus.s_tready}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;

    for (int k = 0; k < 7; k++) run_vec(vecs[k], k + 1);

    // back-to-back frames with tvalid never dropping
    f0 = frames;
    drive_frame(60, 9999, 20, ok);
    drive_frame(60, 9999, 21, ok);
    wait_idle("b2b");
    check("b2b_frames", frames - f0, 2);
    check("b2b_gap", last_gap, 48);
    check("b2b_rdy", last_rdy, 31);
    check("b2b_en", last_en, 288);

    // reset in the middle of a frame
    repeat (60) @(posedge clk);
    #1;
    u0 = un_cnt;
    drive_frame(60, 30, 30, ok);
    check("rst_mid_en", int'(rmii_tx_en), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_outs", int'({rmii_tx_en, rmii_txd, busy, frame_done,
                               underrun, oversize, bus.s_tready}), 0);
    check("rst_mid_un", un_cnt - u0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    run_vec(vecs[0], 31);

    check("txd_idle", idle_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

endmodule
